// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divider sequencer: FSM state encoding,
// default iteration count and iteration-counter width.
package div_pkg;

   // Default number of divider iterations, which is also the operand width
   localparam int N_ITER_DEFAULT = 32;

   // Iteration counter width (covers 0 .. N_ITER_DEFAULT-1)
   localparam int CNT_W = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/div_sequencer_twos_negate.sv
// Two's complement conditioner: conditional negation or absolute value.
// In abs mode the value's own sign bit selects negation; otherwise neg_en does.
module twos_negate #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         abs_mode,
   input  logic         neg_en,
   output logic [W-1:0] result
);

   // Select the negate condition, then negate or pass through
   always_comb begin
      logic flip;
      flip   = abs_mode ? value[W-1] : neg_en;
      result = flip ? ({W{1'b0}} - value) : value;
   end

endmodule

// File: rtl/div_sequencer.sv
// Control sequencer for an external iterative divider.
// Accepts a request, conditions the operands, starts the datapath, counts
// N_ITER iterations, captures the quotient/remainder and strobes completion.
// Divide-by-zero is answered directly without starting the datapath.
// Optional feature: define DIV_SIGNED_EN for two's complement operands
// (magnitudes to the divider, sign fixup of quotient and remainder).
module div_sequencer
   import div_pkg::*;
#(
   parameter int N_ITER = N_ITER_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ctrl_DIV,
   input  logic [N_ITER-1:0] data_operandA,
   input  logic [N_ITER-1:0] data_operandB,
   output logic [N_ITER-1:0] data_result,
   output logic [N_ITER-1:0] data_remainder,
   output logic              data_exception,
   output logic              data_resultRDY,
   output logic              busy,
   output logic [N_ITER-1:0] div_dividend,
   output logic [N_ITER-1:0] div_divisor,
   output logic              div_start,
   output logic              div_result_rdy,
   input  logic [N_ITER-1:0] div_quotient,
   input  logic [N_ITER-1:0] div_remainder
);

`ifdef DIV_SIGNED_EN
   localparam logic SIGNED_EN = 1'b1;
`else
   localparam logic SIGNED_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic [N_ITER-1:0] mag_a, mag_b;
   logic              sign_a, sign_b;
   logic [N_ITER-1:0] abs_a, abs_b, fix_q, fix_r;
   logic              div_by_zero;

   assign div_by_zero = (data_operandB == '0);

   // Operand conditioning: absolute values when signed, pass-through otherwise
   twos_negate #(.W(N_ITER)) u_abs_a (
      .value(data_operandA), .abs_mode(SIGNED_EN), .neg_en(1'b0), .result(abs_a)
   );
   twos_negate #(.W(N_ITER)) u_abs_b (
      .value(data_operandB), .abs_mode(SIGNED_EN), .neg_en(1'b0), .result(abs_b)
   );

   // Result fixup: quotient negative when signs differ, remainder follows dividend
   twos_negate #(.W(N_ITER)) u_fix_q (
      .value(div_quotient), .abs_mode(1'b0), .neg_en(sign_a ^ sign_b), .result(fix_q)
   );
   twos_negate #(.W(N_ITER)) u_fix_r (
      .value(div_remainder), .abs_mode(1'b0), .neg_en(sign_a), .result(fix_r)
   );

   // State register
   // NOTE: all clocked state uses non-blocking assignment so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state logic: a request always wins and restarts from any state
   always_comb begin
      // NOTE: default assignment first so no path leaves state_next unassigned
      // (that would infer a latch).
      state_next = state;
      if (ctrl_DIV) begin
         state_next = div_by_zero ? S_DONE : S_LOAD;
      end else begin
         case (state)
            S_IDLE:  state_next = S_IDLE;
            S_LOAD:  state_next = S_RUN;
            S_RUN:   state_next = (cnt == CNT_LAST) ? S_DONE : S_RUN;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // Output decode from the current state
   always_comb begin
      div_start      = (state == S_LOAD);
      busy           = (state == S_LOAD) || (state == S_RUN);
      div_result_rdy = (state == S_RUN) && (cnt == CNT_LAST);
      data_resultRDY = (state == S_DONE);
   end

   assign div_dividend = mag_a;
   assign div_divisor  = mag_b;

   // Iteration counter: cleared in LOAD (entry to RUN), saturates at the last count
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (state == S_LOAD) begin
         cnt <= '0;
      end else if ((state == S_RUN) && (cnt != CNT_LAST)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Operand registers: magnitudes and signs sampled with every accepted request
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mag_a  <= '0;
         mag_b  <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
      end else if (ctrl_DIV) begin
         mag_a  <= abs_a;
         mag_b  <= abs_b;
         sign_a <= SIGNED_EN & data_operandA[N_ITER-1];
         sign_b <= SIGNED_EN & data_operandB[N_ITER-1];
      end
   end

   // Result registers: divide-by-zero answer on request, datapath capture at the
   // last iteration; otherwise held until the next request produces a result
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_result    <= '0;
         data_remainder <= '0;
         data_exception <= 1'b0;
      end else if (ctrl_DIV && div_by_zero) begin
         data_result    <= '0;
         data_remainder <= '0;
         data_exception <= 1'b1;
      end else if (div_result_rdy && !ctrl_DIV) begin
         data_result    <= fix_q;
         data_remainder <= fix_r;
         data_exception <= 1'b0;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer with a behavioural divider
// datapath. Signed-operand expectations follow DIV_SIGNED_EN.
module tb_div_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_DIV;
   logic [31:0] opA, opB;
   logic [31:0] data_result, data_remainder;
   logic        data_exception, data_resultRDY, busy;
   logic [31:0] div_dividend, div_divisor;
   logic        div_start, div_result_rdy;
   logic [31:0] mq = '0, mr = '0;

   int checks = 0;
   int errors = 0;

`ifdef DIV_SIGNED_EN
   localparam logic [31:0] NEG_Q = 32'hFFFF_FFF2;  // -14
   localparam logic [31:0] NEG_R = 32'hFFFF_FFFE;  // -2
   localparam logic [31:0] MIN_Q = 32'h8000_0000;
   localparam logic [31:0] MIN_R = 32'h0000_0000;
`else
   localparam logic [31:0] NEG_Q = 32'h2492_4916;  // 4294967196 / 7
   localparam logic [31:0] NEG_R = 32'h0000_0002;
   localparam logic [31:0] MIN_Q = 32'h0000_0000;
   localparam logic [31:0] MIN_R = 32'h8000_0000;
`endif

   always #5 clock = ~clock;

   div_sequencer #(.N_ITER(32)) dut (
      .clock(clock), .reset(reset), .ctrl_DIV(ctrl_DIV),
      .data_operandA(opA), .data_operandB(opB),
      .data_result(data_result), .data_remainder(data_remainder),
      .data_exception(data_exception), .data_resultRDY(data_resultRDY),
      .busy(busy), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_start(div_start), .div_result_rdy(div_result_rdy),
      .div_quotient(mq), .div_remainder(mr)
   );

   // Behavioural divider datapath: latches its answer when started
   always @(posedge clock) begin
      if (div_start) begin
         if (div_divisor != 0) begin
            mq <= div_dividend / div_divisor;
            mr <= div_dividend % div_divisor;
         end else begin
            mq <= '1;
            mr <= div_dividend;
         end
      end
   end

   // Drive a request for one cycle; returns #1 after the sampling edge
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      ctrl_DIV = 1'b1;
      opA      = a;
      opB      = b;
      @(posedge clock);
      #1;
      ctrl_DIV = 1'b0;
   endtask

   // Count edges after the sampling edge until the done strobe is visible
   task automatic wait_rdy(input int budget, output int edges, output bit seen,
                           output bit saw_start);
      edges = 0; seen = 1'b0; saw_start = 1'b0;
      while (!seen && edges < budget) begin
         if (div_start) saw_start = 1'b1;
         if (data_resultRDY) seen = 1'b1;
         else begin
            @(posedge clock);
            #1;
            edges++;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; ctrl_DIV = 1'b0; opA = '0; opB = '0;
      #1;
      checks++;
      if ({data_result, data_remainder, data_exception, data_resultRDY, div_start,
           div_result_rdy, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h/%h exc=%b rdy=%b start=%b drdy=%b busy=%b required all 0",
                  data_result, data_remainder, data_exception, data_resultRDY,
                  div_start, div_result_rdy, busy);
      end
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      checks++;
      if ({data_resultRDY, busy, div_start} !== 3'b000) begin
         errors++;
         $display("FAIL idle_after_reset: rdy/busy/start=%b required 000",
                  {data_resultRDY, busy, div_start});
      end
   endtask

   task automatic test_unsigned_basic;
      int edges; bit seen, saw_start;
      start_op(32'd100, 32'd7);
      checks++;
      if (busy !== 1'b1 || div_start !== 1'b1 || div_dividend !== 32'd100 || div_divisor !== 32'd7) begin
         errors++;
         $display("FAIL load_phase: busy=%b start=%b dvd=%0d dvs=%0d required 1 1 100 7",
                  busy, div_start, div_dividend, div_divisor);
      end
      wait_rdy(100, edges, seen, saw_start);
      checks++;
      if (!seen || edges != 33) begin
         errors++;
         $display("FAIL basic_latency: seen=%b edges=%0d required 33", seen, edges);
      end
      checks++;
      if (data_result !== 32'd14 || data_remainder !== 32'd2 || data_exception !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: got q=%0d r=%0d exc=%b required 14 2 0",
                  data_result, data_remainder, data_exception);
      end
      @(posedge clock);
      #1;
      checks++;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== 32'd14) begin
         errors++;
         $display("FAIL basic_strobe_hold: rdy=%b busy=%b q=%0d required 0 0 14",
                  data_resultRDY, busy, data_result);
      end
   endtask

   task automatic test_div_zero;
      int edges; bit seen, saw_start;
      start_op(32'd5, 32'd0);
      // DONE is entered by the sampling edge itself: one edge from the request
      wait_rdy(100, edges, seen, saw_start);
      checks++;
      if (!seen || edges != 0) begin
         errors++;
         $display("FAIL zero_latency: seen=%b extra edges=%0d required 0 beyond the sampling edge",
                  seen, edges);
      end
      checks++;
      if (data_exception !== 1'b1 || data_result !== '0 || data_remainder !== '0) begin
         errors++;
         $display("FAIL zero_result: exc=%b q=%h r=%h required 1 0 0",
                  data_exception, data_result, data_remainder);
      end
      @(posedge clock);
      #1;
      if (div_start) saw_start = 1'b1;
      checks++;
      if (saw_start !== 1'b0 || data_resultRDY !== 1'b0 || data_exception !== 1'b1) begin
         errors++;
         $display("FAIL zero_no_start: start_seen=%b rdy=%b exc=%b required 0 0 1",
                  saw_start, data_resultRDY, data_exception);
      end
   endtask

   task automatic test_signed_neg;
      int edges; bit seen, saw_start;
      start_op(32'hFFFF_FF9C, 32'd7);  // -100 / 7
      wait_rdy(100, edges, seen, saw_start);
      checks++;
      if (!seen || data_result !== NEG_Q || data_remainder !== NEG_R || data_exception !== 1'b0) begin
         errors++;
         $display("FAIL neg_dividend: seen=%b q=%h r=%h exc=%b required %h %h 0",
                  seen, data_result, data_remainder, data_exception, NEG_Q, NEG_R);
      end
   endtask

   task automatic test_min_overflow;
      int edges; bit seen, saw_start;
      start_op(32'h8000_0000, 32'hFFFF_FFFF);
      wait_rdy(100, edges, seen, saw_start);
      checks++;
      if (!seen || edges != 33 || data_result !== MIN_Q || data_remainder !== MIN_R ||
          data_exception !== 1'b0) begin
         errors++;
         $display("FAIL min_overflow: seen=%b edges=%0d q=%h r=%h exc=%b required 33 %h %h 0",
                  seen, edges, data_result, data_remainder, data_exception, MIN_Q, MIN_R);
      end
   endtask

   task automatic test_abort;
      int edges; bit seen, saw_start, early;
      early = 1'b0;
      start_op(32'd100, 32'd7);
      // After 11 more edges the counter holds 10
      for (int k = 0; k < 11; k++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) early = 1'b1;
      end
      checks++;
      if (busy !== 1'b1 || div_result_rdy !== 1'b0) begin
         errors++;
         $display("FAIL abort_midrun: busy=%b drdy=%b required 1 0", busy, div_result_rdy);
      end
      start_op(32'd9, 32'd3);
      wait_rdy(100, edges, seen, saw_start);
      checks++;
      if (early !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_strobe: first-op strobe=%b required 0", early);
      end
      checks++;
      if (!seen || edges != 33 || data_result !== 32'd3 || data_remainder !== 32'd0) begin
         errors++;
         $display("FAIL abort_restart: seen=%b edges=%0d q=%0d r=%0d required 33 3 0",
                  seen, edges, data_result, data_remainder);
      end
   endtask

   task automatic test_reset_mid_run;
      int edges; bit seen, saw_start, strobe;
      strobe = 1'b0;
      start_op(32'd100, 32'd7);
      repeat (5) begin
         @(posedge clock);
         #1;
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({data_result, data_remainder, data_exception, data_resultRDY, div_start,
           div_result_rdy, busy} !== '0) begin
         errors++;
         $display("FAIL reset_midrun_outputs: got %h/%h exc=%b rdy=%b start=%b drdy=%b busy=%b required all 0",
                  data_result, data_remainder, data_exception, data_resultRDY,
                  div_start, div_result_rdy, busy);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY || busy) strobe = 1'b1;
      end
      checks++;
      if (strobe !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_strobe: activity after reset=%b required 0", strobe);
      end
      start_op(32'd8, 32'd2);
      wait_rdy(100, edges, seen, saw_start);
      checks++;
      if (!seen || edges != 33 || data_result !== 32'd4 || data_remainder !== 32'd0) begin
         errors++;
         $display("FAIL after_reset_op: seen=%b edges=%0d q=%0d r=%0d required 33 4 0",
                  seen, edges, data_result, data_remainder);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_div_zero();
      test_signed_neg();
      test_min_overflow();
      test_abort();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog: a stuck run still terminates
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter N_ITER, default 32, number of divider iterations and operand width.
REQ-002 SHALL have ports clock (in, 1, rising-edge clock) and reset (in, 1, asynchronous active-high reset); this clocking/reset scheme is fixed.
REQ-003 SHALL have ports: ctrl_DIV (in, 1, start request); data_operandA (in, 32, dividend); data_operandB (in, 32, divisor).
REQ-004 SHALL have ports: data_result (out, 32, quotient); data_remainder (out, 32, remainder); data_exception (out, 1, divide-by-zero flag); data_resultRDY (out, 1, one-cycle done strobe); busy (out, 1, operation in flight).
REQ-005 SHALL have ports to the downstream divider datapath: div_dividend (out, 32); div_divisor (out, 32); div_start (out, 1); div_result_rdy (out, 1).
REQ-006 SHALL have return ports from the divider datapath: div_quotient (in, 32); div_remainder (in, 32).

Function
REQ-007 SHALL implement the FSM IDLE, LOAD, RUN, DONE.
- IDLE -> LOAD on ctrl_DIV=1 with divisor nonzero.
- IDLE -> DONE on ctrl_DIV=1 with divisor zero.
- LOAD -> RUN unconditionally.
- RUN -> DONE when the iteration counter reaches N_ITER-1.
- DONE -> IDLE unconditionally.
REQ-008 SHALL register operand magnitudes and signs on the edge sampling ctrl_DIV=1; div_dividend and div_divisor SHALL be driven from these registers and SHALL be stable from LOAD through RUN.
REQ-009 SHALL assert div_start combinationally only while in LOAD.
REQ-010 SHALL clear the 5-bit iteration counter on entry to RUN, increment it once per RUN cycle, and never wrap it.
REQ-011 SHALL assert div_result_rdy only in RUN with counter = N_ITER-1, and SHALL capture div_quotient and div_remainder on that edge.
REQ-012 SHALL assert data_resultRDY only in DONE, for exactly one cycle, N_ITER+1 rising edges after the edge that sampled ctrl_DIV (33 at default).
REQ-013 SHALL hold data_result, data_remainder and data_exception stable from DONE until the next accepted ctrl_DIV.
REQ-014 SHALL, when the divisor is zero, reach DONE one edge after sampling ctrl_DIV, with data_exception=1 and data_result=data_remainder=0; the divider SHALL not be started.
REQ-015 SHALL, on ctrl_DIV=1 in LOAD, RUN or DONE, abort the current operation without a data_resultRDY strobe and restart from the new operands, taking the same transition as from IDLE.
REQ-016 SHALL drive busy=1 in LOAD and RUN, and busy=0 otherwise.

Reset
REQ-017 SHALL, on reset assertion (including mid-operation), immediately enter IDLE and force the counter, data_result, data_remainder, data_exception, data_resultRDY, div_start, div_result_rdy and busy to 0, with no strobe emitted.

Configuration
REQ-018 SHALL, with DIV_SIGNED_EN defined:
- treat operands as two's complement;
- pass magnitudes to the divider;
- negate the quotient when operand signs differ;
- give the remainder the sign of the dividend;
- return 0x80000000 with data_exception=0 for 0x80000000 / 0xFFFFFFFF.
REQ-019 SHALL, without DIV_SIGNED_EN, pass operands unmodified and return the divider results unmodified.

Structure
REQ-020 SHALL take the FSM state typedef and the N_ITER default constant from a shared package div_pkg.
REQ-021 SHALL implement negation and absolute value in one sub-module, twos_negate, instantiated for operand conditioning and for result fixup.

Verification
REQ-022 The bench SHALL check 100 / 7, unsigned -> data_result=14 and data_remainder=2, with data_resultRDY exactly 33 edges after ctrl_DIV.
REQ-023 The bench SHALL check -100 / 7 with DIV_SIGNED_EN -> data_result=0xFFFFFFF2 (-14) and data_remainder=0xFFFFFFFE (-2).
REQ-024 The bench SHALL check 5 / 0 -> data_exception=1, data_result=0 and data_resultRDY exactly 1 edge after ctrl_DIV, with div_start never asserted.
REQ-025 The bench SHALL check ctrl_DIV=1 at RUN counter 10 with new operands 9 / 3 -> no strobe for the first operation, and data_result=3 exactly 33 edges after the second ctrl_DIV.
REQ-026 The bench SHALL check reset asserted in RUN -> all outputs 0 immediately and no data_resultRDY; a subsequent 8 / 2 -> data_result=4.
REQ-027 The bench SHALL check 0x80000000 / 0xFFFFFFFF with DIV_SIGNED_EN -> data_result=0x80000000, data_remainder=0 and data_exception=0.
